if_fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined core, directly upstream of the IF/ID pipeline register. It owns the program counter and issues word-addressed requests to instruction memory over a hold-until-ready handshake. It presents {instruction, PC+1} with a valid flag to IF/ID, honours hazard-unit stalls without losing in-flight data (one-entry skid buffer), and applies branch/jump redirects with flush of anything already fetched.

---
 rtl/if_fetch_stage.sv | 130 +++++++++++++
 tb/tb_if_fetch_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a hold-until-ready imem request, buffers one
// instruction in a skid slot under stall, and kills/redirects on branch. IF_PERF_CNT_EN adds perf counters.
module if_fetch_stage #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instruction,
  output logic [ADDR_W-1:0]  if_pc_plus1
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_bubble_cnt
`endif
);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_KILL = 1'b1
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_plus1;
  logic [ADDR_W-1:0]  kill_addr;

  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc1;

  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc1;

  logic               consume;
  logic               xfer;
  logic               pending;

  assign pc_plus1  = pc + ADDR_W'(1);
  assign consume   = out_valid && !stall;

  // A full skid slot blocks new requests; in KILL the abandoned request must still complete.
  assign imem_req  = !rst && ((state == S_KILL) || !skid_valid);
  assign imem_addr = (state == S_KILL) ? kill_addr : pc;

  assign xfer      = imem_req && imem_ready && (state == S_REQ);
  assign pending   = imem_req && !imem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      kill_addr  <= RESET_PC;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_pc1    <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc1   <= '0;
    end else if (redirect_valid) begin
      pc         <= redirect_target;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      if ((state == S_REQ) && pending) begin
        // Request already on the bus must be held to completion; remember it and discard its data.
        kill_addr <= pc;
        state     <= S_KILL;
      end else if ((state == S_KILL) && imem_ready) begin
        state <= S_REQ;
      end
    end else begin
      if ((state == S_KILL) && imem_ready) begin
        state <= S_REQ;
      end

      // xfer only happens with the skid empty, so arriving data goes either to out or to skid.
      if (xfer) begin
        pc <= pc_plus1;
        if (!out_valid || consume) begin
          out_valid <= 1'b1;
          out_instr <= imem_rdata;
          out_pc1   <= pc_plus1;
        end else begin
          skid_valid <= 1'b1;
          skid_instr <= imem_rdata;
          skid_pc1   <= pc_plus1;
        end
      end else if (consume) begin
        if (skid_valid) begin
          out_instr  <= skid_instr;
          out_pc1    <= skid_pc1;
          skid_valid <= 1'b0;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  assign if_valid       = out_valid;
  assign if_instruction = out_valid ? out_instr : '0;
  assign if_pc_plus1    = out_valid ? out_pc1   : '0;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (consume) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (!out_valid && !stall) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: cycle table for streaming/stall/redirect/wrap, hand sequence for kill and async reset.
module tb_if_fetch_stage;

  localparam int unsigned AW = 16;
  localparam int unsigned IW = 32;
  localparam int unsigned NV = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_target = '0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ready = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic          if_valid;
  logic [IW-1:0] if_instruction;
  logic [AW-1:0] if_pc_plus1;
`ifdef IF_PERF_CNT_EN
  logic [31:0]   perf_fetch_cnt;
  logic [31:0]   perf_bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_fetch_stage #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc_plus1    (if_pc_plus1)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  // Memory model: returns the address as data, ready after lat wait cycles of a held request.
  int unsigned lat  = 0;
  int unsigned wcnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      wcnt       = 0;
      imem_ready = 1'b0;
    end else if (imem_req) begin
      imem_rdata = {16'h0000, imem_addr};
      if (wcnt >= lat) begin
        imem_ready = 1'b1;
        wcnt       = 0;
      end else begin
        imem_ready = 1'b0;
        wcnt       = wcnt + 1;
      end
    end else begin
      imem_ready = 1'b0;
      wcnt       = 0;
    end
  end

  // Scoreboard: expected program-order addresses pushed when the driver starts/redirects the flow.
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_a;
  logic [AW-1:0] exp_p1;
  int            pops = 0;
  bit            mon_en = 1'b0;

  task automatic sb_restart(input logic [AW-1:0] start);
    exp_q.delete();
    for (int unsigned k = 0; k < 64; k++) exp_q.push_back(start + AW'(k));
  endtask

  always @(negedge clk) begin
    #1;
    if (!rst && mon_en && !redirect_valid && if_valid && !stall) begin
      checks++;
      pops++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: got instr=%h pc1=%h, expected no instruction", if_instruction, if_pc_plus1);
      end else begin
        exp_a  = exp_q.pop_front();
        exp_p1 = exp_a + 16'd1;
        if (if_instruction !== {16'h0000, exp_a} || if_pc_plus1 !== exp_p1) begin
          errors++;
          $display("FAIL sb_order: got instr=%h pc1=%h, expected instr=%h pc1=%h",
                   if_instruction, if_pc_plus1, {16'h0000, exp_a}, exp_p1);
        end
      end
    end
  end

  // Handshake monitor: a waiting request must keep req and addr stable into the next cycle.
  logic          prev_wait = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  always @(negedge clk) begin
    #1;
    if (rst) begin
      prev_wait = 1'b0;
    end else begin
      if (prev_wait) begin
        checks++;
        if (!imem_req || imem_addr !== prev_addr) begin
          errors++;
          $display("FAIL req_hold: got req=%0b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, prev_addr);
        end
      end
      prev_wait = imem_req && !imem_ready;
      prev_addr = imem_addr;
    end
  end

  task automatic chk(input string nm, input logic ereq, input logic [AW-1:0] eaddr,
                     input logic ev, input logic [IW-1:0] ei, input logic [AW-1:0] ep);
    checks++;
    if (imem_req !== ereq || imem_addr !== eaddr || if_valid !== ev ||
        if_instruction !== ei || if_pc_plus1 !== ep) begin
      errors++;
      $display("FAIL %s: got req=%0b addr=%h valid=%0b instr=%h pc1=%h, expected req=%0b addr=%h valid=%0b instr=%h pc1=%h",
               nm, imem_req, imem_addr, if_valid, if_instruction, if_pc_plus1, ereq, eaddr, ev, ei, ep);
    end
  endtask

  task automatic chk_perf(input string nm, input int ef, input int eb);
`ifdef IF_PERF_CNT_EN
    checks++;
    if (perf_fetch_cnt !== 32'(ef) || perf_bubble_cnt !== 32'(eb)) begin
      errors++;
      $display("FAIL %s: got fetch=%0d bubble=%0d, expected fetch=%0d bubble=%0d",
               nm, perf_fetch_cnt, perf_bubble_cnt, ef, eb);
    end
`else
    if (ef < 0 || eb < 0) $display("perf counters absent in %s", nm);
`endif
  endtask

  typedef struct {
    logic          st;
    logic          rd;
    logic [AW-1:0] tgt;
    logic          ev;
    logic [AW-1:0] ei;
    logic [AW-1:0] ep;
    logic          ereq;
    logic [AW-1:0] ea;
  } vec_t;

  vec_t tbl [NV];

  task automatic setv(input int i, input logic st, input logic rd, input logic [AW-1:0] tgt,
                      input logic ev, input logic [AW-1:0] ei, input logic [AW-1:0] ep,
                      input logic ereq, input logic [AW-1:0] ea);
    tbl[i].st = st;   tbl[i].rd = rd;   tbl[i].tgt = tgt;
    tbl[i].ev = ev;   tbl[i].ei = ei;   tbl[i].ep  = ep;
    tbl[i].ereq = ereq; tbl[i].ea = ea;
  endtask

  int exp_fetch = 0;
  int exp_bub   = 0;
  int exp_pops  = 0;

  initial begin
    //        i  stall rdir  target    valid instr     pc+1      req   addr
    setv( 0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000);
    setv( 1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0001, 1'b1, 16'h0001);
    setv( 2, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h0002, 1'b1, 16'h0002);
    setv( 3, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0003, 1'b1, 16'h0003);
    setv( 4, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0003, 1'b0, 16'h0004);
    setv( 5, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0003, 1'b0, 16'h0004);
    setv( 6, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0003, 1'b0, 16'h0004);
    setv( 7, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0003, 16'h0004, 1'b1, 16'h0004);
    setv( 8, 1'b0, 1'b1, 16'h0040, 1'b1, 16'h0004, 16'h0005, 1'b1, 16'h0005);
    setv( 9, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0040);
    setv(10, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 16'h0041, 1'b1, 16'h0041);
    setv(11, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0041, 16'h0042, 1'b1, 16'h0042);
    setv(12, 1'b0, 1'b1, 16'hFFFE, 1'b1, 16'h0041, 16'h0042, 1'b0, 16'h0043);
    setv(13, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFE);
    setv(14, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFE, 16'hFFFF, 1'b1, 16'hFFFF);
    setv(15, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000);
    setv(16, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0001, 1'b1, 16'h0001);
    setv(17, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h0002, 1'b1, 16'h0002);

    lat = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("reset", 1'b0, 16'h0000, 1'b0, 32'h0, 16'h0000);
    chk_perf("reset_perf", 0, 0);

    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_restart(16'h0000);
    mon_en = 1'b1;

    for (int i = 0; i < int'(NV); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      stall           = tbl[i].st;
      redirect_valid  = tbl[i].rd;
      redirect_target = tbl[i].tgt;
      if (tbl[i].rd) sb_restart(tbl[i].tgt);
      if (tbl[i].ev && !tbl[i].st) exp_fetch++;
      if (!tbl[i].ev && !tbl[i].st) exp_bub++;
      if (tbl[i].ev && !tbl[i].st && !tbl[i].rd) exp_pops++;
      #2;
      chk($sformatf("vec%0d", i), tbl[i].ereq, tbl[i].ea, tbl[i].ev, {16'h0000, tbl[i].ei}, tbl[i].ep);
    end

    // Slow memory from here: 2 wait cycles, ready on the 3rd cycle of each request.
    @(posedge clk);
    #1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    lat = 2;
    #2;
    chk_perf("perf_after_table", exp_fetch, exp_bub);
    exp_pops++;  // instruction 2 is still consumed in this cycle

    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", 1'b0, 16'h0000, 1'b0, 32'h0, 16'h0000);
    chk_perf("async_rst_perf", 0, 0);

    @(posedge clk);
    #1;
    rst = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 16'h0010;
    sb_restart(16'h0010);
    #2 chk("kill_h0", 1'b1, 16'h0000, 1'b0, 32'h0, 16'h0000);
    @(posedge clk); #1 redirect_valid = 1'b0;
    #2 chk("kill_h1", 1'b1, 16'h0000, 1'b0, 32'h0, 16'h0000);
    @(posedge clk); #3 chk("kill_h2", 1'b1, 16'h0000, 1'b0, 32'h0, 16'h0000);
    @(posedge clk); #1;
    redirect_valid  = 1'b1;
    redirect_target = 16'h0080;
    sb_restart(16'h0080);
    #2 chk("req10_h3", 1'b1, 16'h0010, 1'b0, 32'h0, 16'h0000);
    @(posedge clk); #1 redirect_valid = 1'b0;
    #2 chk("kill10_h4", 1'b1, 16'h0010, 1'b0, 32'h0, 16'h0000);
    @(posedge clk); #3 chk("kill10_h5", 1'b1, 16'h0010, 1'b0, 32'h0, 16'h0000);
    @(posedge clk); #3 chk("req80_h6", 1'b1, 16'h0080, 1'b0, 32'h0, 16'h0000);
    @(posedge clk); #3 chk("req80_h7", 1'b1, 16'h0080, 1'b0, 32'h0, 16'h0000);
    @(posedge clk); #3 chk("req80_h8", 1'b1, 16'h0080, 1'b0, 32'h0, 16'h0000);
    @(posedge clk); #3 chk("out80_h9", 1'b1, 16'h0081, 1'b1, 32'h0000_0080, 16'h0081);
    exp_pops++;
    #4;

    checks++;
    if (pops !== exp_pops) begin
      errors++;
      $display("FAIL consume_count: got %0d consumed instructions, expected %0d", pops, exp_pops);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, expected completion within 200000 time units");
    $fatal(1);
  end

endmodule
